// File: rtl/trace_drain.sv
// Drains trace_buffer on request, emitting each word as a framed byte stream:
// SYNC, data bytes MSB first, XOR checksum of the data bytes.
module trace_drain #(
   parameter int          Fpay      = 32,
   parameter int          TB_Depth  = 512,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   localparam int         CNTw      = $clog2(TB_Depth) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            dump_req,
   input  logic            abort,
   input  logic            fifo_empty,
   input  logic [Fpay-1:0] fifo_dout,
   output logic            fifo_rd,
   output logic [7:0]      tx_data,
   output logic            tx_valid,
   input  logic            tx_ready,
   output logic            busy,
   output logic            done,
   output logic [CNTw-1:0] words_sent
);

   localparam int NBD = Fpay / 8;
   localparam int NB  = NBD + 2;
   localparam int FW  = NB * 8;
   localparam int IW  = $clog2(NB);

   typedef enum logic [2:0] {IDLE, RD, LATCH, SEND, FIN} state_t;

   state_t        state, state_nx;
   logic [FW-1:0] frame;
   logic [IW-1:0] idx;
   logic          abort_pend;
   logic          accept;
   logic          last;

   function automatic logic [7:0] xsum(input logic [Fpay-1:0] w);
      logic [7:0] acc;
      acc = '0;
      for (int unsigned i = 0; i < NBD; i++) acc ^= w[i*8 +: 8];
      return acc;
   endfunction

   assign accept = tx_valid && tx_ready;
   assign last   = (idx == IW'(NB - 1));

   always_comb begin
      state_nx = state;
      fifo_rd  = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
      busy     = 1'b1;
      done     = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (dump_req) state_nx = fifo_empty ? FIN : RD;
         end
         RD: begin
            fifo_rd  = 1'b1;
            state_nx = LATCH;
         end
         LATCH: state_nx = SEND;
         SEND: begin
            tx_valid = 1'b1;
            tx_data  = frame[FW-1 -: 8];
            // An abort seen any time during the word only takes effect here, at the frame end
            if (accept && last)
               state_nx = (abort || abort_pend || fifo_empty) ? FIN : RD;
         end
         FIN: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         frame      <= '0;
         idx        <= '0;
         words_sent <= '0;
         abort_pend <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE)
            abort_pend <= 1'b0;
         else if (abort)
            abort_pend <= 1'b1;
         case (state)
            IDLE: if (dump_req) words_sent <= '0;
            LATCH: begin
               frame <= {SYNC_BYTE, fifo_dout, xsum(fifo_dout)};
               idx   <= '0;
            end
            SEND: begin
               if (accept) begin
                  frame <= frame << 8;
                  idx   <= idx + IW'(1);
                  if (last && (words_sent != '1))
                     words_sent <= words_sent + CNTw'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_trace_drain.sv
// Bench for trace_drain: queue-based trace_buffer model and a frame-level
// reference stream built from the words placed in the buffer.
module tb_trace_drain;

   localparam int FPAY = 32;
   localparam int NB   = FPAY / 8 + 2;

   logic            clk = 1'b0;
   logic            reset;
   logic            dump_req;
   logic            abort;
   logic            fifo_empty;
   logic [FPAY-1:0] fifo_dout;
   logic            fifo_rd;
   logic [7:0]      tx_data;
   logic            tx_valid;
   logic            tx_ready;
   logic            busy;
   logic            done;
   logic [9:0]      words_sent;

   trace_drain #(.Fpay(FPAY), .TB_Depth(512), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .reset(reset), .dump_req(dump_req), .abort(abort),
      .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .done(done), .words_sent(words_sent)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ready_pct = 100;

   logic [FPAY-1:0] buf_q[$];
   logic [7:0]      exp_q[$];
   logic [7:0]      got_q[$];
   int              hs_cyc[$];
   int              rd_cyc[$];
   int              done_cyc[$];
   bit              prev_stall = 0;
   logic [7:0]      prev_data = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference framing: SYNC, data bytes MSB first, XOR of data bytes.
   task automatic add_exp(input logic [FPAY-1:0] w);
      logic [7:0] x;
      logic [7:0] b;
      x = 8'h00;
      exp_q.push_back(8'hA5);
      for (int k = FPAY / 8 - 1; k >= 0; k--) begin
         b = 8'((w >> (8 * k)) & 32'hFF);
         exp_q.push_back(b);
         x = x ^ b;
      end
      exp_q.push_back(x);
   endtask

   task automatic load(input logic [FPAY-1:0] w);
      buf_q.push_back(w);
      add_exp(w);
      fifo_empty = 1'b0;
   endtask

   task automatic clear_rec();
      exp_q.delete();
      got_q.delete();
      hs_cyc.delete();
      rd_cyc.delete();
      done_cyc.delete();
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic step();
      bit hs;
      bit rd_now;
      tx_ready = ($urandom_range(99) < ready_pct);
      hs = tx_valid && tx_ready;
      if (prev_stall) begin
         check("stall_valid", 32'(tx_valid), 32'd1);
         check("stall_data", 32'(tx_data), 32'(prev_data));
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (hs) begin
         got_q.push_back(tx_data);
         hs_cyc.push_back(cyc);
      end
      if (fifo_rd) rd_cyc.push_back(cyc);
      if (done) done_cyc.push_back(cyc);
      rd_now = fifo_rd;
      @(posedge clk);
      #1;
      if (rd_now && buf_q.size() > 0) fifo_dout = buf_q.pop_front();
      fifo_empty = (buf_q.size() == 0);
      dump_req = 1'b0;
      @(negedge clk);
      cyc++;
   endtask

   task automatic run(input int limit, input int abort_at, input int rereq_at);
      int n;
      bit rereq_done;
      n = 0;
      rereq_done = 0;
      while (done_cyc.size() == 0 && n < limit) begin
         if (abort_at >= 0 && got_q.size() >= abort_at) abort = 1'b1;
         if (rereq_at >= 0 && !rereq_done && got_q.size() >= rereq_at) begin
            dump_req = 1'b1;
            rereq_done = 1;
         end
         step();
         n++;
      end
      abort = 1'b0;
      if (done_cyc.size() == 0) check("timeout", 32'd0, 32'd1);
      check("busy_end", 32'(busy), 32'd0);
   endtask

   task automatic cmp_stream(input string tag);
      check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_fifo_rd"}, 32'(fifo_rd), 32'd0);
      check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
      check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_words"}, 32'(words_sent), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int req;
      int wsave;
      reset = 1'b0; dump_req = 1'b0; abort = 1'b0; tx_ready = 1'b0;
      fifo_empty = 1'b1; fifo_dout = '0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b1;
      @(negedge clk);

      // Single word, full-rate stream
      clear_rec();
      ready_pct = 100;
      load(32'h12345678);
      check("model_cksum", 32'(exp_q[5]), 32'h08);
      req = cyc; dump_req = 1'b1;
      run(50, -1, -1);
      cmp_stream("w1");
      for (int i = 0; i < hs_cyc.size(); i++) check("w1_hs_cyc", 32'(hs_cyc[i]), 32'(req + 3 + i));
      check("w1_rd_cnt", 32'(rd_cyc.size()), 32'd1);
      if (rd_cyc.size() > 0) check("w1_rd_cyc", 32'(rd_cyc[0]), 32'(req + 1));
      check("w1_done_cnt", 32'(done_cyc.size()), 32'd1);
      if (done_cyc.size() > 0 && hs_cyc.size() > 0)
         check("w1_done_cyc", 32'(done_cyc[0]), 32'(hs_cyc[hs_cyc.size()-1] + 1));
      check("w1_words", 32'(words_sent), 32'd1);

      // Three words with zero checksums, word period NB+2
      clear_rec();
      load(32'hFFFFFFFF); load(32'h00000000); load(32'hA5A5A5A5);
      req = cyc; dump_req = 1'b1;
      run(100, -1, -1);
      cmp_stream("w3");
      for (int i = 0; i < hs_cyc.size(); i++)
         check("w3_hs_cyc", 32'(hs_cyc[i]), 32'(req + 3 + (NB + 2) * (i / NB) + (i % NB)));
      check("w3_rd_cnt", 32'(rd_cyc.size()), 32'd3);
      for (int k = 0; k < rd_cyc.size(); k++)
         check("w3_rd_cyc", 32'(rd_cyc[k]), 32'(req + 1 + (NB + 2) * k));
      check("w3_words", 32'(words_sent), 32'd3);

      // Random backpressure
      clear_rec();
      ready_pct = 50;
      for (int k = 0; k < 4; k++) load($urandom);
      dump_req = 1'b1;
      run(400, -1, -1);
      cmp_stream("bp");
      check("bp_rd_cnt", 32'(rd_cyc.size()), 32'd4);
      check("bp_words", 32'(words_sent), 32'd4);
      ready_pct = 100;

      // Abort while word 1 byte 2 is on the stream
      clear_rec();
      for (int k = 0; k < 5; k++) load($urandom);
      exp_q = exp_q[0:NB-1];
      dump_req = 1'b1;
      run(100, 2, -1);
      cmp_stream("ab");
      check("ab_words", 32'(words_sent), 32'd1);
      check("ab_rd_cnt", 32'(rd_cyc.size()), 32'd1);
      check("ab_left", 32'(buf_q.size()), 32'd4);
      buf_q.delete();
      fifo_empty = 1'b1;
      repeat (2) step();

      // Empty buffer dump
      clear_rec();
      dump_req = 1'b1;
      step();
      check("emp_busy1", 32'(busy), 32'd1);
      check("emp_done1", 32'(done), 32'd1);
      check("emp_valid1", 32'(tx_valid), 32'd0);
      step();
      check("emp_busy2", 32'(busy), 32'd0);
      check("emp_done2", 32'(done), 32'd0);
      check("emp_words", 32'(words_sent), 32'd0);
      check("emp_bytes", 32'(got_q.size()), 32'd0);

      // Second request while busy is ignored
      clear_rec();
      for (int k = 0; k < 3; k++) load($urandom);
      dump_req = 1'b1;
      run(100, -1, NB + 1);
      cmp_stream("rq");
      check("rq_words", 32'(words_sent), 32'd3);
      check("rq_done_cnt", 32'(done_cyc.size()), 32'd1);

      // Reset in the middle of word 2
      clear_rec();
      for (int k = 0; k < 3; k++) load($urandom);
      dump_req = 1'b1;
      wsave = 0;
      while (got_q.size() < NB + 3 && wsave < 100) begin step(); wsave++; end
      check("rst_reach", 32'(got_q.size()), 32'(NB + 3));
      check("rst_words_pre", 32'(words_sent), 32'd1);
      reset = 1'b0;
      step();
      check_idle_outputs("rst");
      reset = 1'b1;
      prev_stall = 0;
      step();
      clear_rec();
      foreach (buf_q[i]) add_exp(buf_q[i]);
      req = cyc; dump_req = 1'b1;
      run(100, -1, -1);
      cmp_stream("post");
      if (hs_cyc.size() > 0) check("post_first", 32'(hs_cyc[0]), 32'(req + 3));
      check("post_words", 32'(words_sent), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
